// File: rtl/pong_pkg.sv
// Shared Pong types and defaults.
// Match states, score width and match tuning constants.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } match_state_t;

  localparam int SCORE_W          = 4;
  localparam int DEF_WIN_SCORE    = 9;
  localparam int DEF_SERVE_FRAMES = 120;

endpackage

// File: rtl/pong_edge_detect.sv
// Single-input edge detector.
// History register reset value is chosen per input.
module pong_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic hist;

  // Track the previous sample of d
  always_ff @(posedge clk) begin
    if (rst) hist <= RST_VAL;
    else     hist <= d;
  end

  assign rise = d & ~hist;
  assign fall = ~d & hist;

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer.
// Serves, scores points and declares the winner.
module match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync,
  input  logic               start,
  input  logic               leftlost,
  input  logic               rightlost,
  output logic               paused,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               game_over,
  output logic               winner,
  output logic [1:0]         state
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);
  localparam logic [SCORE_W-1:0] WIN =
    SCORE_W'(WIN_SCORE);

  logic tick, vs_rise;
  logic st_rise, st_fall;
  logic ll_rise, ll_fall;
  logic rl_rise, rl_fall;
  logic unused_edges;

  pong_edge_detect #(.RST_VAL(1'b0)) u_vs (
    .clk  (clk),
    .rst  (rst),
    .d    (vsync),
    .rise (vs_rise),
    .fall (tick)
  );

  pong_edge_detect #(.RST_VAL(1'b1)) u_st (
    .clk  (clk),
    .rst  (rst),
    .d    (start),
    .rise (st_rise),
    .fall (st_fall)
  );

  pong_edge_detect #(.RST_VAL(1'b1)) u_ll (
    .clk  (clk),
    .rst  (rst),
    .d    (leftlost),
    .rise (ll_rise),
    .fall (ll_fall)
  );

  pong_edge_detect #(.RST_VAL(1'b1)) u_rl (
    .clk  (clk),
    .rst  (rst),
    .d    (rightlost),
    .rise (rl_rise),
    .fall (rl_fall)
  );

  assign unused_edges =
    vs_rise ^ st_fall ^ ll_fall ^ rl_fall;

  match_state_t       st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] sl_q, sl_d;
  logic [SCORE_W-1:0] sr_q, sr_d;
  logic               win_q, win_d;
  logic               paused_q;
  logic               over_q;

  // Next-state, frame counter and score update
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    sl_d  = sl_q;
    sr_d  = sr_q;
    win_d = win_q;
    unique case (st_q)
      IDLE: begin
        if (st_rise) begin
          st_d  = SERVE;
          cnt_d = CNT_LOAD;
        end
      end
      SERVE: begin
        if (tick) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) st_d = PLAY;
        end
      end
      PLAY: begin
        if (ll_rise) begin
          sr_d = sr_q + 1'b1;
          if (sr_d == WIN) begin
            st_d  = OVER;
            win_d = 1'b1;
          end else begin
            st_d  = SERVE;
            cnt_d = CNT_LOAD;
          end
        end else if (rl_rise) begin
          sl_d = sl_q + 1'b1;
          if (sl_d == WIN) begin
            st_d  = OVER;
            win_d = 1'b0;
          end else begin
            st_d  = SERVE;
            cnt_d = CNT_LOAD;
          end
        end
      end
      OVER: begin
        if (st_rise) begin
          st_d  = SERVE;
          cnt_d = CNT_LOAD;
          sl_d  = '0;
          sr_d  = '0;
          win_d = 1'b0;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Match registers, outputs decoded from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      sl_q     <= '0;
      sr_q     <= '0;
      win_q    <= 1'b0;
      paused_q <= 1'b1;
      over_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      sl_q     <= sl_d;
      sr_q     <= sr_d;
      win_q    <= win_d;
      paused_q <= (st_d != PLAY);
      over_q   <= (st_d == OVER);
    end
  end

  assign paused      = paused_q;
  assign score_left  = sl_q;
  assign score_right = sr_q;
  assign game_over   = over_q;
  assign winner      = win_q;
  assign state       = st_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller.
// Directed match flow plus random play vs a reference model.
module tb_match_controller;

  localparam int W  = 5;
  localparam int SF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync = 1'b0;
  logic       start = 1'b0;
  logic       leftlost = 1'b0;
  logic       rightlost = 1'b0;
  logic       paused;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;
  logic       winner;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  match_controller #(
    .WIN_SCORE    (W),
    .SERVE_FRAMES (SF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .start       (start),
    .leftlost    (leftlost),
    .rightlost   (rightlost),
    .paused      (paused),
    .score_left  (score_left),
    .score_right (score_right),
    .game_over   (game_over),
    .winner      (winner),
    .state       (state)
  );

  always #5 clk = ~clk;

  // reference model: 0 idle, 1 waiting serve, 2 rally, 3 finished
  int m_ph = 0;
  int m_frames = 0;
  int m_sl = 0;
  int m_sr = 0;
  int m_win = 0;
  bit p_vs = 0, p_st = 1, p_ll = 1, p_rl = 1;

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic award(bit right_side);
    int s;
    if (right_side) begin
      m_sr = m_sr + 1;
      s = m_sr;
    end else begin
      m_sl = m_sl + 1;
      s = m_sl;
    end
    if (s == W) begin
      m_ph = 3;
      m_win = right_side ? 1 : 0;
    end else begin
      m_ph = 1;
      m_frames = SF;
    end
  endtask

  task automatic model(bit r, bit vs, bit st,
                       bit ll, bit rl);
    bit tk, sr, lr, rr;
    if (r) begin
      m_ph = 0; m_frames = 0;
      m_sl = 0; m_sr = 0; m_win = 0;
      p_vs = 0; p_st = 1; p_ll = 1; p_rl = 1;
      return;
    end
    tk = p_vs && !vs;
    sr = st && !p_st;
    lr = ll && !p_ll;
    rr = rl && !p_rl;
    p_vs = vs; p_st = st; p_ll = ll; p_rl = rl;
    if (m_ph == 0) begin
      if (sr) begin m_ph = 1; m_frames = SF; end
    end else if (m_ph == 1) begin
      if (tk) begin
        m_frames = m_frames - 1;
        if (m_frames == 0) m_ph = 2;
      end
    end else if (m_ph == 2) begin
      if (lr) award(1'b1);
      else if (rr) award(1'b0);
    end else begin
      if (sr) begin
        m_sl = 0; m_sr = 0; m_win = 0;
        m_ph = 1; m_frames = SF;
      end
    end
  endtask

  task automatic compare_all();
    check("state", int'(state), m_ph);
    check("paused", int'(paused), (m_ph != 2) ? 1 : 0);
    check("score_left", int'(score_left), m_sl);
    check("score_right", int'(score_right), m_sr);
    check("game_over", int'(game_over), (m_ph == 3) ? 1 : 0);
    check("winner", int'(winner), m_win);
  endtask

  task automatic step(bit r, bit vs, bit st, bit ll, bit rl);
    rst = r; vsync = vs; start = st;
    leftlost = ll; rightlost = rl;
    model(r, vs, st, ll, rl);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic hold(int n);
    for (int i = 0; i < n; i++)
      step(1'b0, vsync, start, leftlost, rightlost);
  endtask

  task automatic press();
    step(1'b0, vsync, 1'b0, leftlost, rightlost);
    step(1'b0, vsync, 1'b1, leftlost, rightlost);
    step(1'b0, vsync, 1'b0, leftlost, rightlost);
  endtask

  task automatic frame();
    step(1'b0, 1'b1, start, leftlost, rightlost);
    step(1'b0, 1'b1, start, leftlost, rightlost);
    step(1'b0, 1'b0, start, leftlost, rightlost);
    step(1'b0, 1'b0, start, leftlost, rightlost);
  endtask

  task automatic serve();
    for (int i = 0; i < SF; i++) frame();
  endtask

  task automatic point(bit left_side_lost);
    if (left_side_lost) begin
      step(1'b0, vsync, start, 1'b1, 1'b0);
      step(1'b0, vsync, start, 1'b0, 1'b0);
    end else begin
      step(1'b0, vsync, start, 1'b0, 1'b1);
      step(1'b0, vsync, start, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // reset with start held high
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_paused", int'(paused), 1);
    check("rst_state", int'(state), 0);
    hold(10);
    check("idle_hold", int'(state), 0);

    // serve timing
    press();
    check("serve_entry", int'(state), 1);
    frame(); frame();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_third_tick", int'(paused), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("play_after_tick", int'(state), 2);
    check("play_unpaused", int'(paused), 0);

    // long leftlost level scores once
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ll_one_cycle", int'(score_right), 1);
    check("ll_back_serve", int'(state), 1);
    hold(499);
    check("ll_held", int'(score_right), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // simultaneous rises: left has priority
    serve();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("both_right", int'(score_right), 2);
    check("both_left", int'(score_left), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // right player wins, further points ignored
    for (int i = 0; i < 3; i++) begin
      serve();
      point(1'b1);
    end
    check("win_over", int'(game_over), 1);
    check("win_side", int'(winner), 1);
    point(1'b1);
    point(1'b0);
    check("over_frozen", int'(score_right), W);
    press();
    check("restart_state", int'(state), 1);
    check("restart_score", int'(score_right), 0);

    // build 3-4, reset mid serve
    for (int i = 0; i < 3; i++) begin
      serve(); point(1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      serve(); point(1'b1);
    end
    check("pre_rst_left", int'(score_left), 3);
    check("pre_rst_right", int'(score_right), 4);
    frame();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_left", int'(score_left), 0);
    check("mid_rst_right", int'(score_right), 0);
    press();
    frame(); frame();
    check("restart_no_play", int'(state), 1);
    frame();
    check("restart_play", int'(state), 2);

    // random play against the model
    for (int i = 0; i < 6000; i++) begin
      bit r, vs, st, ll, rl;
      r  = ($urandom_range(0, 1999) == 0);
      vs = ($urandom_range(0, 3) == 0) ? !vsync : vsync;
      st = ($urandom_range(0, 29) == 0) ? !start : start;
      ll = ($urandom_range(0, 19) == 0)
             ? !leftlost : leftlost;
      rl = ($urandom_range(0, 19) == 0)
             ? !rightlost : rightlost;
      step(r, vs, st, ll, rl);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
